// File: rtl/mult24_arb.sv
// Two-requester arbiter/sequencer around a shared multicycle 24x24 multiplier.
// Optional: MULT24_ARB_ZERO_BYPASS_EN returns zero products without the CALC wait.
module mult24 (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  assign p = {24'b0, a} * {24'b0, b};
endmodule

module mult24_arb #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_a,
  input  logic [23:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_a,
  input  logic [23:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [47:0] rsp0_s,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [47:0] rsp1_s,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  localparam logic [2:0] LAST = 3'(MUL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] op_a_q, op_a_d;
  logic [23:0] op_b_q, op_b_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [47:0] res_q, res_d;

  logic        grant;
  logic [23:0] sel_a;
  logic [23:0] sel_b;
  logic [47:0] prod;
  logic        rsp_take;

  mult24 u_mult24 (
    .a(op_a_q),
    .b(op_b_q),
    .p(prod)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = (req0_valid & req1_valid) ? prio_q : req1_valid;
    sel_a      = grant ? req1_a : req0_a;
    sel_b      = grant ? req1_b : req0_b;
    rsp_take   = owner_q ? rsp1_ready : rsp0_ready;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so nothing is accepted while reset is held.
        req0_ready = ~rst & req0_valid & ~grant;
        req1_ready = ~rst & req1_valid & grant;
        if (req0_ready | req1_ready) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          owner_d = grant;
          cnt_d   = 3'd0;
          state_d = CALC;
`ifdef MULT24_ARB_ZERO_BYPASS_EN
          if (sel_a == 24'd0 || sel_b == 24'd0) begin
            res_d   = 48'd0;
            state_d = RESP;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) begin
          res_d   = prod;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp0_s     = rsp0_valid ? res_q : 48'd0;
  assign rsp1_s     = rsp1_valid ? res_q : 48'd0;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mult24_arb.sv
// Bench for mult24_arb: directed scenarios plus random ops against a
// transaction-level model (alternating priority, a*b, fixed latency).
module tb_mult24_arb;
  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [47:0] rsp0_s, rsp1_s;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit prio_m = 1'b0;

  mult24_arb #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    tick();
    rst = 1'b0;
    prio_m = 1'b0;
    #1;
  endtask

  task automatic do_op(bit v0, bit v1, logic [23:0] a0, logic [23:0] b0,
                       logic [23:0] a1, logic [23:0] b1, int hold, bit scr);
    bit g;
    logic [23:0] ga, gb;
    logic [47:0] exp_s, held_s;
    int exp_lat, lat;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    g = (v0 && v1) ? prio_m : v1;
    ga = g ? a1 : a0;
    gb = g ? b1 : b0;
    exp_s = 48'(longint'(ga) * longint'(gb));
    exp_lat = MUL_CYCLES + 1;
`ifdef MULT24_ARB_ZERO_BYPASS_EN
    if (ga == 24'd0 || gb == 24'd0) exp_lat = 1;
`endif
    chk("busy_idle", 64'(busy), 64'd0);
    chk("grant_ready", 64'({req1_ready, req0_ready}), g ? 64'd2 : 64'd1);
    tick();
    if (scr) begin
      req0_a = 24'($urandom); req0_b = 24'($urandom);
      req1_a = 24'($urandom); req1_b = 24'($urandom);
    end
    lat = 1;
    #1;
    while (!(rsp0_valid || rsp1_valid) && lat < 20) begin
      chk("calc_busy_ready", 64'({busy, req1_ready, req0_ready}), 64'b100);
      tick();
      lat++;
      #1;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (!(rsp0_valid || rsp1_valid)) begin
      do_reset();
      return;
    end
    chk("rsp_valid", 64'({rsp1_valid, rsp0_valid}), g ? 64'd2 : 64'd1);
    chk("rsp_s", 64'(g ? rsp1_s : rsp0_s), 64'(exp_s));
    chk("rsp_other_s", 64'(g ? rsp0_s : rsp1_s), 64'd0);
    chk("resp_ready", 64'({busy, req1_ready, req0_ready}), 64'b100);
    held_s = exp_s;
    for (int i = 0; i < hold; i++) begin
      tick();
      #1;
      chk("hold_valid", 64'({rsp1_valid, rsp0_valid}), g ? 64'd2 : 64'd1);
      chk("hold_s", 64'(g ? rsp1_s : rsp0_s), 64'(held_s));
      chk("hold_ready", 64'({req1_ready, req0_ready}), 64'd0);
    end
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    #1;
    chk("idle_after", 64'({busy, rsp1_valid, rsp0_valid}), 64'd0);
    prio_m = !g;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    chk("rst_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    chk("rst_s", 64'({rsp1_s, rsp0_s}), 64'd0);

    do_op(1, 0, 24'd5, 24'd7, 24'd0, 24'd0, 0, 0);
    do_op(0, 1, 24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF, 0, 0);

    do_reset();
    for (int i = 0; i < 3; i++)
      do_op(1, 1, 24'd3, 24'd4, 24'd6, 24'd7, 0, 0);

    do_op(1, 1, 24'd5, 24'd7, 24'd9, 24'd9, 5, 0);

    req0_valid = 1'b1; req0_a = 24'd5; req0_b = 24'd7;
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prio_m = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out", 64'({rsp1_valid, rsp0_valid, rsp1_s, rsp0_s}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("midrst_novalid", 64'({busy, rsp1_valid, rsp0_valid}), 64'd0);
    end
    do_op(1, 1, 24'd11, 24'd13, 24'd2, 24'd3, 0, 0);

    do_op(1, 0, 24'd0, 24'h123456, 24'd0, 24'd0, 0, 0);
    do_op(0, 1, 24'd0, 24'd0, 24'h000042, 24'd0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      bit v0, v1;
      logic [23:0] a0, b0, a1, b1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
      b0 = 24'($urandom);
      a1 = 24'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
      do_op(v0, v1, a0, b0, a1, b1, $urandom_range(0, 3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
